// File: rtl/dma_arbiter.sv
// -----------------------------------------------------------------------------
// dma_arbiter
//   Shares one TL-UH DMA host port into the coherent interconnect between
//   NumHosts IO DMA engines.
//
//   Channel A: round-robin arbitration. A grant is held while the device
//   stalls the first beat, and for the whole of a multi-beat Put. The device
//   source is {host index, host source}.
//   Channel D: routed back to the requester named by the upper source bits.
//   The source is stripped back to the host width.
//
//   The path is pure pass-through with zero added latency and no data
//   buffering. Only arbitration state is registered.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   host_a_valid_i   per-requester A valid                    [NumHosts]
//   host_a_ready_o   per-requester A ready                    [NumHosts]
//   host_a_i         per-requester A payload, host source     [NumHosts*HostAW]
//   host_d_valid_o   per-requester D valid                    [NumHosts]
//   host_d_ready_i   per-requester D ready                    [NumHosts]
//   host_d_o         D payload, shared, host source           [HostDW]
//   dev_a_valid_o    DMA port A valid
//   dev_a_ready_i    DMA port A ready
//   dev_a_o          A payload, device source                 [DevAW]
//   dev_d_valid_i    DMA port D valid
//   dev_d_ready_o    DMA port D ready
//   dev_d_i          D payload, device source                 [DevDW]
//   err_o            1-cycle pulse per D beat with an unroutable source
//
// Payload layouts (MSB..LSB)
//   A: opcode[2:0] size[2:0] source address mask[DataWidth/8] data
//   D: opcode[2:0] size[2:0] source denied data
// -----------------------------------------------------------------------------

// Per-requester slice.
// Decodes the shared grant and D routing into this lane's handshakes.
module dma_arbiter_lane #(
    parameter int Lane = 0,
    parameter int IdxW = 1
) (
    input  logic            rst_ni,
    input  logic            gnt_any,
    input  logic [IdxW-1:0] gnt_idx,
    input  logic            dev_a_ready,
    input  logic            d_valid,
    input  logic [IdxW-1:0] d_idx,
    output logic            host_a_ready,
    output logic            host_d_valid
);

    logic is_gnt;
    logic is_dst;

    assign is_gnt = gnt_any & (gnt_idx == IdxW'(Lane));
    assign is_dst = d_idx == IdxW'(Lane);

    // Handshakes are forced low while reset is asserted.
    // Upstream sees no accept while the arbiter is being cleared.
    assign host_a_ready = rst_ni & dev_a_ready & is_gnt;
    assign host_d_valid = rst_ni & d_valid & is_dst;

endmodule

module dma_arbiter #(
    parameter int NumHosts        = 2,
    parameter int DataWidth       = 128,
    parameter int AddrWidth       = 38,
    parameter int HostSourceWidth = 2,
    parameter int SourceWidth     = HostSourceWidth + $clog2(NumHosts),
    localparam int IdxW           = $clog2(NumHosts),
    localparam int MaskW          = DataWidth / 8,
    localparam int HostAW         = 6 + HostSourceWidth + AddrWidth + MaskW + DataWidth,
    localparam int DevAW          = 6 + SourceWidth + AddrWidth + MaskW + DataWidth,
    localparam int HostDW         = 6 + HostSourceWidth + 1 + DataWidth,
    localparam int DevDW          = 6 + SourceWidth + 1 + DataWidth
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic [NumHosts-1:0]        host_a_valid_i,
    output logic [NumHosts-1:0]        host_a_ready_o,
    input  logic [NumHosts*HostAW-1:0] host_a_i,
    output logic [NumHosts-1:0]        host_d_valid_o,
    input  logic [NumHosts-1:0]        host_d_ready_i,
    output logic [HostDW-1:0]          host_d_o,

    output logic                       dev_a_valid_o,
    input  logic                       dev_a_ready_i,
    output logic [DevAW-1:0]           dev_a_o,
    input  logic                       dev_d_valid_i,
    output logic                       dev_d_ready_o,
    input  logic [DevDW-1:0]           dev_d_i,

    output logic                       err_o
);

    // log2 of bytes per beat.
    // Put sizes above this value span multiple beats.
    localparam int LogBeatBytes = $clog2(MaskW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no lock, grant follows the round-robin pick
        HOLD  = 2'd1,   // first beat offered but stalled, grant frozen
        BURST = 2'd2    // multi-beat Put in progress, grant frozen
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [7:0]        beats_left_q, beats_left_d;
    logic              err_q;

    logic [NumHosts-1:0][HostAW-1:0] host_a;

    // Round-robin candidate search.
    logic [IdxW-1:0]   cand;
    logic [IdxW-1:0]   rr_idx;
    logic              rr_found;

    // Effective grant for this cycle.
    logic              gnt_any;
    logic [IdxW-1:0]   gnt_idx;
    logic [HostAW-1:0] gnt_pay;
    logic [2:0]        gnt_op;
    logic [2:0]        gnt_size;
    logic [7:0]        gnt_beats;
    logic [IdxW-1:0]   rr_next;
    logic              a_valid;
    logic              a_fire;

    // D routing.
    logic [IdxW-1:0]   d_idx;
    logic              d_routable;

    assign host_a = host_a_i;

    // ------------------------------------------------------------------
    // Round-robin pick: first valid requester at or after rr_ptr.
    // The search wraps to 0. Only used while IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        cand     = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int off = 0; off < NumHosts; off++) begin
            cand = IdxW'((int'(rr_ptr_q) + off) % NumHosts);
            if (!rr_found && host_a_valid_i[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // HOLD and BURST pin the grant to the locked requester.
    // This keeps the payload stable under backpressure, and keeps the beats
    // of a Put contiguous.
    assign gnt_any  = (state_q == IDLE) ? rr_found : 1'b1;
    assign gnt_idx  = (state_q == IDLE) ? rr_idx   : grant_q;
    assign gnt_pay  = host_a[gnt_idx];
    assign gnt_op   = gnt_pay[HostAW-1 -: 3];
    assign gnt_size = gnt_pay[HostAW-4 -: 3];

    assign a_valid  = gnt_any & host_a_valid_i[gnt_idx];
    assign a_fire   = a_valid & dev_a_ready_i;

    assign rr_next  = (gnt_idx == IdxW'(NumHosts - 1)) ? '0 : gnt_idx + 1'b1;

    // Only PutFull (0) and PutPartial (1) carry data on A.
    // A Get of any size is a single A beat; its burst comes back on D.
    always_comb begin
        gnt_beats = 8'd1;
        if ((gnt_op == 3'd0 || gnt_op == 3'd1) && int'(gnt_size) > LogBeatBytes)
            gnt_beats = 8'd1 << (int'(gnt_size) - LogBeatBytes);
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beats_left_d = beats_left_q;
        rr_ptr_d     = rr_ptr_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (a_fire) begin
                    grant_d = gnt_idx;
                    if (gnt_beats > 8'd1) begin
                        state_d      = BURST;
                        beats_left_d = gnt_beats - 8'd1;
                    end else begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_next;
                    end
                end else if (a_valid) begin
                    // Offered but not taken.
                    // Freeze so a later, higher-priority requester cannot
                    // swap the payload under a pending valid.
                    state_d = HOLD;
                    grant_d = gnt_idx;
                end
            end
            BURST: begin
                if (a_fire) begin
                    beats_left_d = beats_left_q - 8'd1;
                    if (beats_left_q == 8'd1) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            beats_left_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            beats_left_q <= beats_left_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Channel A output.
    // The host index is spliced in above the host source. The host source
    // immediately follows opcode/size, so the remainder copies through.
    // ------------------------------------------------------------------
    assign dev_a_valid_o = rst_ni & a_valid;
    assign dev_a_o       = {gnt_pay[HostAW-1 -: 6], gnt_idx, gnt_pay[HostAW-7:0]};

    // ------------------------------------------------------------------
    // Channel D.
    // Routed purely by source, so it runs independently of the A lock.
    // ------------------------------------------------------------------
    assign d_idx      = dev_d_i[DevDW-7 -: IdxW];
    assign d_routable = int'(d_idx) < NumHosts;
    assign host_d_o   = {dev_d_i[DevDW-1 -: 6], dev_d_i[DevDW-7-IdxW:0]};

    // An unroutable beat is sunk so the device stream cannot deadlock.
    // Only possible when NumHosts is not a power of two.
    assign dev_d_ready_o = rst_ni & (d_routable ? host_d_ready_i[d_idx] : 1'b1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= dev_d_valid_i & ~d_routable;
    end

    assign err_o = err_q;

    // ------------------------------------------------------------------
    // Per-requester handshake decode
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NumHosts; i++) begin : g_lane
        dma_arbiter_lane #(
            .Lane (i),
            .IdxW (IdxW)
        ) u_lane (
            .rst_ni       (rst_ni),
            .gnt_any      (gnt_any),
            .gnt_idx      (gnt_idx),
            .dev_a_ready  (dev_a_ready_i),
            .d_valid      (dev_d_valid_i & d_routable),
            .d_idx        (d_idx),
            .host_a_ready (host_a_ready_o[i]),
            .host_d_valid (host_d_valid_o[i])
        );
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_arbiter
//   Directed scenarios followed by a randomized phase.
//
//   Stimulus pushes expected device-side A beats (per host) and expected
//   host-side D beats into scoreboards. A separate monitor compares them.
//
//   Arbitration is modelled at transaction level:
//     - The winner is the first valid host at or after the pointer.
//     - The winner owns the port until all of its beats are taken.
//     - The pointer then moves one past the winner.
// -----------------------------------------------------------------------------
module tb_dma_arbiter;

    localparam int NumHosts  = 2;
    localparam int DataWidth = 128;
    localparam int AddrWidth = 38;
    localparam int HSW       = 2;
    localparam int SW        = 3;
    localparam int IdxW      = $clog2(NumHosts);
    localparam int LogBytes  = $clog2(DataWidth / 8);
    localparam int HAW       = 6 + HSW + AddrWidth + DataWidth / 8 + DataWidth;
    localparam int DAW       = HAW + IdxW;
    localparam int HDW       = 6 + HSW + 1 + DataWidth;
    localparam int DDW       = HDW + IdxW;

    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_PUTP = 3'd1;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_AAD  = 3'd1;  // AccessAckData

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NumHosts-1:0]           hv, ha_rdy, hd_vld, hd_rdy;
    logic [NumHosts-1:0][HAW-1:0]  hp;
    logic [HDW-1:0]                hd_pay;
    logic                          dav, dar, ddv, ddr, err;
    logic [DAW-1:0]                da_pay;
    logic [DDW-1:0]                dd_pay;

    dma_arbiter #(
        .NumHosts        (NumHosts),
        .DataWidth       (DataWidth),
        .AddrWidth       (AddrWidth),
        .HostSourceWidth (HSW),
        .SourceWidth     (SW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .host_a_valid_i (hv),
        .host_a_ready_o (ha_rdy),
        .host_a_i       (hp),
        .host_d_valid_o (hd_vld),
        .host_d_ready_i (hd_rdy),
        .host_d_o       (hd_pay),
        .dev_a_valid_o  (dav),
        .dev_a_ready_i  (dar),
        .dev_a_o        (da_pay),
        .dev_d_valid_i  (ddv),
        .dev_d_ready_o  (ddr),
        .dev_d_i        (dd_pay),
        .err_o          (err)
    );

    typedef struct {
        int             idx;
        logic [HDW-1:0] pay;
    } d_exp_t;

    logic [HAW-1:0] hq    [NumHosts][$];   // beats each host still has to send
    logic [DAW-1:0] exp_a [NumHosts][$];   // expected device view of those beats
    logic [DDW-1:0] dq[$];                 // device D beats to send
    d_exp_t         exp_d[$];

    int   checks = 0;
    int   errors = 0;
    logic rnd_a  = 1'b0;
    logic rnd_d  = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int beats_of(input logic [2:0] op, input logic [2:0] size);
        if ((op == OP_PUTF || op == OP_PUTP) && int'(size) > LogBytes)
            return 1 << (int'(size) - LogBytes);
        return 1;
    endfunction

    // Present the head of each queue; called right after every posedge.
    task automatic drive();
        for (int h = 0; h < NumHosts; h++) begin
            hv[h] = hq[h].size() > 0;
            hp[h] = (hq[h].size() > 0) ? hq[h][0] : '0;
        end
        ddv    = dq.size() > 0;
        dd_pay = (dq.size() > 0) ? dq[0] : '0;
    endtask

    task automatic push_a(input int h, input logic [2:0] op, input logic [2:0] size);
        logic [HAW-1:0]  r;
        logic [HSW-1:0]  src;
        int n;
        n   = beats_of(op, size);
        src = HSW'($urandom);
        for (int b = 0; b < n; b++) begin
            r                 = HAW'(rnd256());
            r[HAW-1 -: 3]     = op;
            r[HAW-4 -: 3]     = size;
            r[HAW-7 -: HSW]   = src;
            hq[h].push_back(r);
            exp_a[h].push_back({r[HAW-1 -: 6], IdxW'(h), r[HAW-7:0]});
        end
        drive();
    endtask

    task automatic push_d(input logic [SW-1:0] src, input int n, input logic [2:0] op);
        logic [DDW-1:0] r;
        d_exp_t e;
        for (int b = 0; b < n; b++) begin
            r              = DDW'(rnd256());
            r[DDW-1 -: 3]  = op;
            r[DDW-7 -: SW] = src;
            dq.push_back(r);
            e.idx = int'(src[SW-1]);
            e.pay = {r[DDW-1 -: 6], r[DDW-8:0]};
            exp_d.push_back(e);
        end
        drive();
    endtask

    // One cycle.
    // Handshakes are sampled at the negedge. Queues are advanced and inputs
    // re-driven just after the posedge.
    task automatic tick();
        logic [NumHosts-1:0] acc;
        logic dacc;
        @(negedge clk);
        acc  = hv & ha_rdy;
        dacc = ddv & ddr;
        @(posedge clk);
        #1;
        for (int h = 0; h < NumHosts; h++)
            if (acc[h] && hq[h].size() > 0) void'(hq[h].pop_front());
        if (dacc && dq.size() > 0) void'(dq.pop_front());
        if (rnd_a) dar = ($urandom_range(0, 3) != 0);
        if (rnd_d) hd_rdy = NumHosts'($urandom);
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((hq[0].size() > 0 || hq[1].size() > 0 || dq.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        if (hq[0].size() > 0 || hq[1].size() > 0 || dq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d beats pending expected=0",
                     hq[0].size() + hq[1].size() + dq.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    int ptr  = 0;
    int win  = -1;
    int left = 0;

    initial begin : monitor
        logic [NumHosts-1:0] er;
        logic [DAW-1:0]      ea;
        d_exp_t              ed;
        logic                ev;
        int                  cand;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_dev_a_valid", dav, 0);
                chk("rst_host_a_ready", ha_rdy, 0);
                chk("rst_host_d_valid", hd_vld, 0);
                chk("rst_dev_d_ready", ddr, 0);
                chk("rst_err", err, 0);
                ptr  = 0;
                win  = -1;
                left = 0;
            end else begin
                // Channel A: pick a winner at a transaction boundary.
                if (win < 0) begin
                    for (int k = 0; k < NumHosts; k++) begin
                        cand = (ptr + k) % NumHosts;
                        if (win < 0 && hv[cand]) begin
                            win  = cand;
                            left = 0;
                        end
                    end
                end
                ev = (win >= 0) && hv[win];
                chk("dev_a_valid", dav, ev);
                er = '0;
                if (win >= 0 && dar) er[win] = 1'b1;
                chk("host_a_ready", ha_rdy, er);
                if (ev) begin
                    if (exp_a[win].size() == 0) begin
                        chk("exp_a_underflow", 1, 0);
                    end else begin
                        ea = exp_a[win][0];
                        chk("dev_a_payload", da_pay, ea);
                        if (dar) begin
                            void'(exp_a[win].pop_front());
                            if (left == 0) left = beats_of(ea[DAW-1 -: 3], ea[DAW-4 -: 3]);
                            left--;
                            if (left == 0) begin
                                ptr = (win + 1) % NumHosts;
                                win = -1;
                            end
                        end
                    end
                end

                // Channel D: routing, ready propagation, source stripping.
                if (ddv) begin
                    if (exp_d.size() == 0) begin
                        chk("exp_d_underflow", 1, 0);
                    end else begin
                        ed = exp_d[0];
                        er = '0;
                        er[ed.idx] = 1'b1;
                        chk("host_d_valid", hd_vld, er);
                        chk("dev_d_ready", ddr, hd_rdy[ed.idx]);
                        chk("host_d_payload", hd_pay, ed.pay);
                        if (hd_rdy[ed.idx]) void'(exp_d.pop_front());
                    end
                end else begin
                    chk("host_d_valid_idle", hd_vld, 0);
                end
                chk("err_o", err, 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        hv = '0; hp = '0; hd_rdy = '1; dar = 1'b1; ddv = 1'b0; dd_pay = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Both hosts Get 64B together: host0 first, then host1.
        push_a(0, OP_GET, 3'd6);
        push_a(1, OP_GET, 3'd6);
        drain(50);

        // Host0 4-beat PutFull with host1 waiting: contiguous burst first.
        push_a(0, OP_PUTF, 3'd6);
        push_a(1, OP_GET, 3'd2);
        drain(50);

        // Device stalls 3 cycles; host1 arrives mid-stall and must not steal.
        dar = 1'b0;
        push_a(0, OP_GET, 3'd3);
        tick();
        push_a(1, OP_GET, 3'd3);
        tick();
        tick();
        dar = 1'b1;
        drain(50);

        // 4-beat AccessAckData to source 3'b110, host readies random.
        rnd_d = 1'b1;
        push_d(3'b110, 4, OP_AAD);
        drain(100);
        rnd_d  = 1'b0;
        hd_rdy = '1;

        // Move pointer to host1, then reset during beat 3 of a host0 burst.
        push_a(0, OP_GET, 3'd0);
        drain(20);
        push_a(0, OP_PUTF, 3'd6);
        for (int n = 0; n < 20 && hq[0].size() > 2; n++) tick();
        rst_n = 1'b0;
        tick();
        for (int h = 0; h < NumHosts; h++) begin
            hq[h].delete();
            exp_a[h].delete();
        end
        dq.delete();
        exp_d.delete();
        drive();
        tick();
        rst_n = 1'b1;
        tick();

        // Pointer must be back at 0: host0 wins the tie.
        push_a(0, OP_GET, 3'd1);
        push_a(1, OP_GET, 3'd1);
        drain(50);

        // Host1 alone, 5 single-beat requests back to back.
        for (int k = 0; k < 5; k++) push_a(1, OP_GET, 3'd0);
        drain(50);

        // Randomized traffic on both channels.
        rnd_a = 1'b1;
        rnd_d = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int h = 0; h < NumHosts; h++) begin
                if (hq[h].size() == 0 && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       push_a(h, OP_PUTF, 3'($urandom_range(0, 6)));
                        1:       push_a(h, OP_PUTP, 3'($urandom_range(0, 6)));
                        default: push_a(h, OP_GET,  3'($urandom_range(0, 7)));
                    endcase
                end
            end
            if (dq.size() < 3 && $urandom_range(0, 2) == 0)
                push_d(SW'($urandom), $urandom_range(1, 4), OP_AAD);
            tick();
        end
        rnd_a  = 1'b0;
        rnd_d  = 1'b0;
        dar    = 1'b1;
        hd_rdy = '1;
        drain(2000);
        repeat (3) tick();

        chk("exp_a_leftover", exp_a[0].size() + exp_a[1].size(), 0);
        chk("exp_d_leftover", exp_d.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
